// File: rtl/ceas_alarma_if.sv
// ---------------------------------------------------------------------------
// ceas_alarma_if
//
// Command and display bus between the button-control front end and the
// clock/alarm core.
//
//   Commands (driven by the button front end, consumed by the core):
//     semnal_setare    level, high = clock-edit mode requested
//     semnal_setare_a  level, high = alarm-edit mode requested
//     semnal_stop      rising edge leaves edit mode / silences the alarm
//     semnal_b1        rising edge increments hours
//     semnal_b2        rising edge increments minutes
//   Status (driven by the core, read by the display/BCD layer):
//     ore, minute, secunde   time of day (binary)
//     ore_a, minute_a        alarm time (binary)
//     mod_editare            00 RUN, 01 SET_CLK, 10 SET_AL
//     alarma_armata          alarm enabled
//     alarma                 alarm ringing
//
// Modports:
//   master - button/display side (drives commands, reads status)
//   slave  - clock/alarm core    (reads commands, drives status)
// ---------------------------------------------------------------------------
interface ceas_alarma_if;
    logic       semnal_setare;
    logic       semnal_setare_a;
    logic       semnal_stop;
    logic       semnal_b1;
    logic       semnal_b2;

    logic [4:0] ore;
    logic [5:0] minute;
    logic [5:0] secunde;
    logic [4:0] ore_a;
    logic [5:0] minute_a;
    logic [1:0] mod_editare;
    logic       alarma_armata;
    logic       alarma;

    modport master (
        output semnal_setare,
        output semnal_setare_a,
        output semnal_stop,
        output semnal_b1,
        output semnal_b2,
        input  ore,
        input  minute,
        input  secunde,
        input  ore_a,
        input  minute_a,
        input  mod_editare,
        input  alarma_armata,
        input  alarma
    );

    modport slave (
        input  semnal_setare,
        input  semnal_setare_a,
        input  semnal_stop,
        input  semnal_b1,
        input  semnal_b2,
        output ore,
        output minute,
        output secunde,
        output ore_a,
        output minute_a,
        output mod_editare,
        output alarma_armata,
        output alarma
    );
endinterface

// File: rtl/ceas_alarma_core.sv
// ---------------------------------------------------------------------------
// ceas_alarma_core
//
// Time-of-day clock with a single daily alarm. Owns the seconds prescaler,
// the hh:mm:ss counter, the alarm hh:mm registers, the edit-mode FSM and the
// ringing alarm output.
//
// Parameters:
//   TICKS_PER_SEC  clock cycles per second (>= 2)
//   ALARM_SECONDS  maximum time the alarm rings, in seconds
//
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      ceas_alarma_if.slave - command inputs and time/alarm status
//
// Modes (mod_editare):
//   00 RUN      time runs, alarm may fire
//   01 SET_CLK  time frozen, seconds held at 0, b1/b2 edit hours/minutes
//   10 SET_AL   time runs, b1/b2 edit alarm hours/minutes
// ---------------------------------------------------------------------------
module ceas_alarma_core #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int ALARM_SECONDS = 60
) (
    input  logic         clock,
    input  logic         reset_n,
    ceas_alarma_if.slave bus
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int RW = (ALARM_SECONDS > 0) ? $clog2(ALARM_SECONDS + 1) : 1;

    localparam logic [PW-1:0] PRESC_TC  = PW'(TICKS_PER_SEC - 1);
    localparam logic [RW-1:0] RING_LOAD = RW'(ALARM_SECONDS);

    // Bit positions in the command history vector
    localparam int C_SETARE   = 0;
    localparam int C_SETARE_A = 1;
    localparam int C_STOP     = 2;
    localparam int C_B1       = 3;
    localparam int C_B2       = 4;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_CLK = 2'b01,
        ST_SET_AL  = 2'b10
    } state_e;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    state_e          state_q,    state_d;
    logic [4:0]      hist_q,     hist_d;
    logic [PW-1:0]   presc_q,    presc_d;
    logic [4:0]      ore_q,      ore_d;
    logic [5:0]      minute_q,   minute_d;
    logic [5:0]      secunde_q,  secunde_d;
    logic [4:0]      ore_a_q,    ore_a_d;
    logic [5:0]      minute_a_q, minute_a_d;
    logic            armata_q,   armata_d;
    logic            alarma_q,   alarma_d;
    logic [RW-1:0]   ring_q,     ring_d;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic [4:0] cmd;
    logic [4:0] rise;
    logic       fall_setare;
    logic       fall_setare_a;
    logic       consume;
    logic       eff_stop;
    logic       eff_b1;
    logic       eff_b2;
    logic       tick;
    logic [4:0] ore_adv;
    logic [5:0] minute_adv;
    logic [5:0] secunde_adv;

    function automatic logic [4:0] inc_mod24(input logic [4:0] v);
        return (v >= 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] inc_mod60(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    assign cmd = {bus.semnal_b2, bus.semnal_b1, bus.semnal_stop,
                  bus.semnal_setare_a, bus.semnal_setare};

    assign rise          = cmd & ~hist_q;
    assign fall_setare   = hist_q[C_SETARE]   & ~cmd[C_SETARE];
    assign fall_setare_a = hist_q[C_SETARE_A] & ~cmd[C_SETARE_A];

    // While the alarm rings, the first b1/b2/stop edge only silences it.
    assign consume  = alarma_q & (rise[C_B1] | rise[C_B2] | rise[C_STOP]);
    assign eff_stop = rise[C_STOP] & ~consume;
    assign eff_b1   = rise[C_B1]   & ~consume;
    assign eff_b2   = rise[C_B2]   & ~consume;

    // The prescaler is parked at 0 in SET_CLK, but it may still hold the
    // terminal count on the first cycle after entry, hence the state gate.
    assign tick = (state_q != ST_SET_CLK) && (presc_q == PRESC_TC);

    // Next time-of-day if a one-second tick is applied now
    always_comb begin
        ore_adv     = ore_q;
        minute_adv  = minute_q;
        secunde_adv = secunde_q;
        if (secunde_q >= 6'd59) begin
            secunde_adv = 6'd0;
            if (minute_q >= 6'd59) begin
                minute_adv = 6'd0;
                ore_adv    = inc_mod24(ore_q);
            end else begin
                minute_adv = minute_q + 6'd1;
            end
        end else begin
            secunde_adv = secunde_q + 6'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hist_d     = cmd;
        presc_d    = presc_q;
        ore_d      = ore_q;
        minute_d   = minute_q;
        secunde_d  = secunde_q;
        ore_a_d    = ore_a_q;
        minute_a_d = minute_a_q;
        armata_d   = armata_q;
        alarma_d   = alarma_q;
        ring_d     = ring_q;

        // Prescaler
        if (state_q == ST_SET_CLK || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        // Time advance
        if (tick) begin
            ore_d     = ore_adv;
            minute_d  = minute_adv;
            secunde_d = secunde_adv;
        end

        // Ring duration countdown
        if (alarma_q && tick) begin
            if (ring_q <= RW'(1)) begin
                ring_d   = '0;
                alarma_d = 1'b0;
            end else begin
                ring_d = ring_q - RW'(1);
            end
        end

        if (consume) begin
            alarma_d = 1'b0;
            ring_d   = '0;
        end

        // Alarm fires only on a tick in RUN that lands on hh:mm:00
        if (tick && state_q == ST_RUN && armata_q &&
            ore_adv == ore_a_q && minute_adv == minute_a_q &&
            secunde_adv == 6'd0) begin
            alarma_d = 1'b1;
            ring_d   = RING_LOAD;
        end

        // Mode FSM
        case (state_q)
            ST_RUN: begin
                if (rise[C_SETARE]) begin
                    state_d = ST_SET_CLK;
                end else if (rise[C_SETARE_A]) begin
                    state_d  = ST_SET_AL;
                    armata_d = 1'b0;
                    alarma_d = 1'b0;
                    ring_d   = '0;
                end
            end

            ST_SET_CLK: begin
                secunde_d = 6'd0;
                if (eff_stop || fall_setare) begin
                    state_d = ST_RUN;
                end else begin
                    if (eff_b1) ore_d    = inc_mod24(ore_q);
                    if (eff_b2) minute_d = inc_mod60(minute_q);
                end
            end

            ST_SET_AL: begin
                if (eff_stop) begin
                    state_d  = ST_RUN;
                    armata_d = 1'b1;
                end else if (fall_setare_a) begin
                    state_d  = ST_RUN;
                    armata_d = 1'b0;
                end else begin
                    if (eff_b1) ore_a_d    = inc_mod24(ore_a_q);
                    if (eff_b2) minute_a_d = inc_mod60(minute_a_q);
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            hist_q     <= '0;
            presc_q    <= '0;
            ore_q      <= '0;
            minute_q   <= '0;
            secunde_q  <= '0;
            ore_a_q    <= '0;
            minute_a_q <= '0;
            armata_q   <= 1'b0;
            alarma_q   <= 1'b0;
            ring_q     <= '0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            presc_q    <= presc_d;
            ore_q      <= ore_d;
            minute_q   <= minute_d;
            secunde_q  <= secunde_d;
            ore_a_q    <= ore_a_d;
            minute_a_q <= minute_a_d;
            armata_q   <= armata_d;
            alarma_q   <= alarma_d;
            ring_q     <= ring_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.ore           = ore_q;
    assign bus.minute        = minute_q;
    assign bus.secunde       = secunde_q;
    assign bus.ore_a         = ore_a_q;
    assign bus.minute_a      = minute_a_q;
    assign bus.mod_editare   = state_q;
    assign bus.alarma_armata = armata_q;
    assign bus.alarma        = alarma_q;

endmodule
